// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller (master) reads decoder fields and memory status and drives
// every mux select, enable and ALU strobe. The datapath (slave) does the
// opposite. pc_load is the PC enable the datapath actually uses: either the
// unconditional load or the conditional load, qualified by the branch sense.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    // Decoder and datapath status
    logic [5:0]       op;
    logic [5:0]       func;
    logic             zero;
    logic             mem_ready;

    // Control strobes and selects
    logic             pc_write;
    logic             pc_write_c;
    logic             branch_ne;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    // Effective PC enable: BEQ takes on zero, BNE takes on not-zero
    logic             pc_load;
    assign pc_load = pc_write | (pc_write_c & (zero ^ branch_ne));

    modport master (
        input  op, func, mem_ready,
        output pc_write, pc_write_c, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, instr_count
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  pc_write, pc_write_c, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, instr_count, pc_load
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Sequences FETCH -> DECODE -> per-class execute states, Moore-decodes every
// datapath control from the state register (FETCH's IR/PC load strobes are
// additionally qualified by mem_ready), and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus
);

    // Supported opcodes and the JR function code
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // ALU source / operation / PC source encodings
    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;
    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_SUB    = 2'd1;
    localparam logic [1:0] ALU_FUNC   = 2'd2;
    localparam logic [1:0] ALU_ADDI   = 2'd3;
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EXEC   = 4'd2,
        S_R_WB     = 4'd3,
        S_I_EXEC   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    // Control outputs, decoded from state_q
    logic       pc_write, pc_write_c, branch_ne, i_or_d;
    logic       mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    // Next-state selection and retire detection
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:      state_d = (bus.func == FN_JR) ? S_JR : S_R_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_I_EXEC;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: begin
                state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
                retire  = bus.mem_ready;
            end
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            // ILLEGAL returns to FETCH without retiring; spare encodings recover
            default:    state_d = S_FETCH;
        endcase
    end

    // Retired-instruction count, wrapping naturally at all-ones
    always_comb begin
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    // State register and retired-instruction counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples pre-edge values regardless of order.
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Moore output decode, forced to zero while reset is held
    always_comb begin
        pc_write   = 1'b0;
        pc_write_c = 1'b0;
        branch_ne  = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        pc_source  = PCS_ALU;
        illegal_op = 1'b0;
        // NOTE: the outputs are gated by rst directly rather than registered,
        // so nothing escapes the instant reset falls and FETCH controls are
        // present the instant it releases, without waiting for a clock.
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMMSH;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNC;
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADDI;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_write_c = 1'b1;
                    pc_source  = PCS_ALUOUT;
                    branch_ne  = (bus.op == OP_BNE);
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_JUMP;
                end
                S_JR: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_RS;
                end
                S_ILLEGAL: begin
                    illegal_op = 1'b1;
                end
                default: begin
                    illegal_op = 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.pc_write_c  = pc_write_c;
    assign bus.branch_ne   = branch_ne;
    assign bus.i_or_d      = i_or_d;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.ir_write    = ir_write;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.reg_dst     = reg_dst;
    assign bus.reg_write   = reg_write;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_op      = alu_op;
    assign bus.pc_source   = pc_source;
    assign bus.illegal_op  = illegal_op;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. A driver issues instructions one cycle at a
// time and pushes the hand-written expected control vector for every cycle
// into a scoreboard queue; a monitor pops one entry per falling edge and
// compares. A second instance with a 4-bit counter sees identical stimulus.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic rst;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();
    mips_multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.master)
    );

    assign bus4.op        = bus.op;
    assign bus4.func      = bus.func;
    assign bus4.zero      = bus.zero;
    assign bus4.mem_ready = bus.mem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout, MSB first:
    // pcw pcwc bne iord mr mw irw m2r rd rw asa asb[1:0] aop[1:0] psrc[1:0] ill
    localparam logic [17:0] V_FRDY  = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [17:0] V_FWAIT = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [17:0] V_DEC   = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [17:0] V_REX   = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [17:0] V_RWB   = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [17:0] V_IEX   = 18'b0_0_0_0_0_0_0_0_0_0_1_10_11_00_0;
    localparam logic [17:0] V_IWB   = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [17:0] V_MADR  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [17:0] V_MRD   = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] V_MWB   = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [17:0] V_MWR   = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] V_BEQ   = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] V_BNE   = 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] V_JMP   = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [17:0] V_JR    = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_11_0;
    localparam logic [17:0] V_ILL   = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;
    localparam logic [17:0] V_ZERO  = 18'b0;

    typedef struct {
        string       name;
        logic [18:0] vec;   // control vector plus effective PC load
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 32'd0;

    // Effective PC load the datapath should see for a given control vector
    function automatic logic pc_load_of(input logic [17:0] v, input logic z);
        return v[17] | (v[16] & (z ^ v[15]));
    endfunction

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [18:0] act;
            e   = sb.pop_front();
            act = {bus.pc_write, bus.pc_write_c, bus.branch_ne, bus.i_or_d,
                   bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                   bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                   bus.alu_op, bus.pc_source, bus.illegal_op, bus.pc_load};
            checks++;
            if (act !== e.vec || bus.instr_count !== e.cnt ||
                bus4.instr_count !== e.cnt[3:0]) begin
                failures++;
                $display("FAIL %s: got vec=%b cnt=%0d cnt4=%0d, want vec=%b cnt=%0d cnt4=%0d",
                         e.name, act, bus.instr_count, bus4.instr_count,
                         e.vec, e.cnt, e.cnt[3:0]);
            end
        end
    end

    // Issue one instruction: fw FETCH wait states, mw MEM_RD/MEM_WR wait
    // states. cut >= 0 stops after that many cycles and pulses reset.
    task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int fw, input int mw, input int cut);
        logic [17:0] seq[$];
        logic        rdy[$];
        bit          ret;
        int          n;
        ret = 1'b1;
        repeat (fw) begin seq.push_back(V_FWAIT); rdy.push_back(1'b0); end
        seq.push_back(V_FRDY); rdy.push_back(1'b1);
        seq.push_back(V_DEC);  rdy.push_back(1'b0);
        case (o)
            6'h00: begin
                if (f == 6'h08) begin
                    seq.push_back(V_JR); rdy.push_back(1'b0);
                end else begin
                    seq.push_back(V_REX); rdy.push_back(1'b0);
                    seq.push_back(V_RWB); rdy.push_back(1'b0);
                end
            end
            6'h23: begin
                seq.push_back(V_MADR); rdy.push_back(1'b0);
                repeat (mw) begin seq.push_back(V_MRD); rdy.push_back(1'b0); end
                seq.push_back(V_MRD); rdy.push_back(1'b1);
                seq.push_back(V_MWB); rdy.push_back(1'b0);
            end
            6'h2B: begin
                seq.push_back(V_MADR); rdy.push_back(1'b0);
                repeat (mw) begin seq.push_back(V_MWR); rdy.push_back(1'b0); end
                seq.push_back(V_MWR); rdy.push_back(1'b1);
            end
            6'h04: begin seq.push_back(V_BEQ); rdy.push_back(1'b0); end
            6'h05: begin seq.push_back(V_BNE); rdy.push_back(1'b0); end
            6'h08: begin
                seq.push_back(V_IEX); rdy.push_back(1'b0);
                seq.push_back(V_IWB); rdy.push_back(1'b0);
            end
            6'h02: begin seq.push_back(V_JMP); rdy.push_back(1'b0); end
            default: begin
                seq.push_back(V_ILL); rdy.push_back(1'b0);
                ret = 1'b0;
            end
        endcase
        n = (cut >= 0) ? cut : seq.size();
        for (int i = 0; i < n; i++) begin
            sb.push_back('{name: $sformatf("%s[%0d]", nm, i),
                           vec: {seq[i], pc_load_of(seq[i], z)}, cnt: exp_cnt});
        end
        bus.op   = o;
        bus.func = f;
        bus.zero = z;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = rdy[i];
            @(posedge clk);
            #1;
        end
        if (cut >= 0) begin
            rst     = 1'b0;
            exp_cnt = 32'd0;
            sb.push_back('{name: {nm, "_in_reset"}, vec: 19'b0, cnt: 32'd0});
            @(posedge clk);
            #1;
            rst = 1'b1;
        end else if (ret) begin
            exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.op        = 6'h2B;
        bus.func      = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{name: "por_reset", vec: {V_ZERO, 1'b0}, cnt: 32'd0});
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_instr("add",  6'h00, 6'h20, 1'b0, 0, 0, -1);
        run_instr("lw",   6'h23, 6'h00, 1'b0, 2, 3, -1);
        run_instr("beq",  6'h04, 6'h00, 1'b1, 0, 0, -1);
        run_instr("bne",  6'h05, 6'h00, 1'b0, 0, 0, -1);
        run_instr("ill",  6'h3F, 6'h00, 1'b0, 0, 0, -1);
        run_instr("jr",   6'h00, 6'h08, 1'b0, 0, 0, -1);
        run_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0, -1);
        run_instr("j",    6'h02, 6'h00, 1'b0, 1, 0, -1);
        run_instr("sw",   6'h2B, 6'h00, 1'b0, 0, 1, -1);
        // Reset lands while MEM_WR is stalled, with a nonzero count
        run_instr("sw_cut", 6'h2B, 6'h00, 1'b0, 0, 3, 4);
        for (int k = 0; k < 17; k++) begin
            run_instr("sw_wrap", 6'h2B, 6'h00, 1'b0, 0, 0, -1);
        end
        // Count is 17 here, so the 4-bit instance must read 1
        run_instr("ill_end", 6'h3F, 6'h00, 1'b0, 0, 0, -1);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
